// File: rtl/ifft4_pkg.sv
// Shared constants and types for the streaming 4-point inverse FFT.
package ifft4_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      STG1  = 2'd1,
      STG2  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int FRAME_LEN      = 4;
   localparam int SCALE_SHIFT    = 2;
   localparam int DEF_DATA_WIDTH = 10;

endpackage

// File: rtl/ifft4_stream_if.sv
// Sample-in / sample-out handshake bundle of the inverse FFT; slave is the block side.
interface ifft4_stream_if #(
   parameter int DATA_WIDTH = 10
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] in_real;
   logic signed [DATA_WIDTH-1:0] in_imag;
   logic                         out_valid;
   logic                         out_ready;
   logic                         out_last;
   logic signed [DATA_WIDTH-1:0] out_real;
   logic signed [DATA_WIDTH-1:0] out_imag;

   modport master (
      output in_valid, in_real, in_imag, out_ready,
      input  in_ready, out_valid, out_last, out_real, out_imag
   );

   modport slave (
      input  in_valid, in_real, in_imag, out_ready,
      output in_ready, out_valid, out_last, out_real, out_imag
   );
endinterface

// File: rtl/ifft4_butterfly.sv
// Combinational radix-2 butterfly: complex sum and difference, one bit of growth.
module ifft4_butterfly #(
   parameter int W = 10
) (
   input  logic signed [W-1:0] a_re_i,
   input  logic signed [W-1:0] a_im_i,
   input  logic signed [W-1:0] b_re_i,
   input  logic signed [W-1:0] b_im_i,
   output logic signed [W:0]   sum_re_o,
   output logic signed [W:0]   sum_im_o,
   output logic signed [W:0]   dif_re_o,
   output logic signed [W:0]   dif_im_o
);

   assign sum_re_o = a_re_i + b_re_i;
   assign sum_im_o = a_im_i + b_im_i;
   assign dif_re_o = a_re_i - b_re_i;
   assign dif_im_o = a_im_i - b_im_i;

endmodule

// File: rtl/ifft4_stream.sv
// Streaming 4-point inverse FFT: buffer X0..X3, two registered radix-2 stages,
// drain x0..x3 scaled by 1/4 with floor rounding.
module ifft4_stream
   import ifft4_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input logic          clk,
   input logic          rst,
   ifft4_stream_if.slave bus
);

   localparam int W1 = DATA_WIDTH + 1;
   localparam int W2 = DATA_WIDTH + 2;

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [1:0] ocnt_q, ocnt_d;

   logic signed [DATA_WIDTH-1:0] buf_re_q [FRAME_LEN];
   logic signed [DATA_WIDTH-1:0] buf_im_q [FRAME_LEN];
   logic signed [W1-1:0]         a_re_q   [FRAME_LEN];
   logic signed [W1-1:0]         a_im_q   [FRAME_LEN];
   logic signed [W2-1:0]         s_re_q   [FRAME_LEN];
   logic signed [W2-1:0]         s_im_q   [FRAME_LEN];

   logic signed [W1-1:0] stg1_re [FRAME_LEN];
   logic signed [W1-1:0] stg1_im [FRAME_LEN];
   logic signed [W2-1:0] stg2_re [FRAME_LEN];
   logic signed [W2-1:0] stg2_im [FRAME_LEN];
   logic signed [W1-1:0] rot_re, rot_im;
   logic signed [W2-1:0] out_sel_re, out_sel_im;

   logic accept, emit;

   assign accept = bus.in_valid && (state_q == LOAD);
   assign emit   = bus.out_ready && (state_q == DRAIN);

   // Stage 1 pairs inputs in bit-reversed order: (X0,X2) and (X1,X3).
   ifft4_butterfly #(.W(DATA_WIDTH)) u_bf_02 (
      .a_re_i(buf_re_q[0]), .a_im_i(buf_im_q[0]),
      .b_re_i(buf_re_q[2]), .b_im_i(buf_im_q[2]),
      .sum_re_o(stg1_re[0]), .sum_im_o(stg1_im[0]),
      .dif_re_o(stg1_re[1]), .dif_im_o(stg1_im[1])
   );

   ifft4_butterfly #(.W(DATA_WIDTH)) u_bf_13 (
      .a_re_i(buf_re_q[1]), .a_im_i(buf_im_q[1]),
      .b_re_i(buf_re_q[3]), .b_im_i(buf_im_q[3]),
      .sum_re_o(stg1_re[2]), .sum_im_o(stg1_im[2]),
      .dif_re_o(stg1_re[3]), .dif_im_o(stg1_im[3])
   );

   // Inverse twiddle +j applied to a3: (re, im) -> (-im, re). |a3i| < 2^DATA_WIDTH, so no wrap.
   assign rot_re = -a_im_q[3];
   assign rot_im =  a_re_q[3];

   ifft4_butterfly #(.W(W1)) u_bf_even (
      .a_re_i(a_re_q[0]), .a_im_i(a_im_q[0]),
      .b_re_i(a_re_q[2]), .b_im_i(a_im_q[2]),
      .sum_re_o(stg2_re[0]), .sum_im_o(stg2_im[0]),
      .dif_re_o(stg2_re[2]), .dif_im_o(stg2_im[2])
   );

   ifft4_butterfly #(.W(W1)) u_bf_odd (
      .a_re_i(a_re_q[1]), .a_im_i(a_im_q[1]),
      .b_re_i(rot_re),    .b_im_i(rot_im),
      .sum_re_o(stg2_re[1]), .sum_im_o(stg2_im[1]),
      .dif_re_o(stg2_re[3]), .dif_im_o(stg2_im[3])
   );

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         ocnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ocnt_q  <= ocnt_d;
      end
   end

   // NOTE: the sample buffer and stage registers carry no reset; outputs are
   // gated by state, so their contents are never visible before being written.
   always_ff @(posedge clk) begin
      if (accept) begin
         buf_re_q[cnt_q] <= bus.in_real;
         buf_im_q[cnt_q] <= bus.in_imag;
      end
      if (state_q == STG1) begin
         a_re_q <= stg1_re;
         a_im_q <= stg1_im;
      end
      if (state_q == STG2) begin
         s_re_q <= stg2_re;
         s_im_q <= stg2_im;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ocnt_d  = ocnt_q;
      unique case (state_q)
         LOAD: begin
            if (accept) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = STG1;
            end
         end
         STG1: state_d = STG2;
         STG2: state_d = DRAIN;
         DRAIN: begin
            if (emit) begin
               ocnt_d = ocnt_q + 2'd1;
               if (ocnt_q == 2'd3) state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // Dropping the two LSBs of the signed sum is the floor-rounded divide by 4.
   always_comb begin
      out_sel_re = s_re_q[ocnt_q];
      out_sel_im = s_im_q[ocnt_q];
      bus.out_real = '0;
      bus.out_imag = '0;
      if (state_q == DRAIN) begin
         bus.out_real = out_sel_re[W2-1:SCALE_SHIFT];
         bus.out_imag = out_sel_im[W2-1:SCALE_SHIFT];
      end
   end

   assign bus.in_ready  = (state_q == LOAD);
   assign bus.out_valid = (state_q == DRAIN);
   assign bus.out_last  = (state_q == DRAIN) && (ocnt_q == 2'd3);

endmodule
